bist_sequencer: RTL
===================

# bist_sequencer

RUNBIST controller for the TAP core-logic FSM. When the RUNBIST instruction is active, it takes the core logic through a fixed sequence: reset, seed state load, then a burst of LFSR-generated X patterns. It compacts the resulting Y responses into an 8-bit MISR signature and compares that signature with a golden value to give a pass/fail flag. It sits between the TAP instruction decode and the core-logic inputs, and drives them on the functional `clk` domain.

## Interface

Parameters:
- `PATTERNS`, default 8'd15: number of X patterns applied per run. Legal range 1..255.
- `SEED`, default 4'b1001: LFSR seed. Must be nonzero.
- `INIT_STATE`, default 4'b0000: core state forced before the first pattern.

Ports:
- `clk` input 1: single clock. All logic on posedge.
- `RST_N` input 1: asynchronous, active-low reset.
- `RUNBIST_EN` input 1: level signal, RUNBIST instruction selected. Must be high for a run to start or continue.
- `START` input 1: run request. Sampled only in IDLE or DONE.
- `GOLDEN` input 8: expected signature. Sampled in the COMPARE cycle.
- `CL_Y` input 4: core-logic state output (Y).
- `CL_X` output 4: core-logic X input.
- `CL_RESET_SM` output 1: core-logic reset.
- `CL_ASSIGN_STATE` output 1: core-logic state load.
- `CL_RUNBIST` output 1: drives RUNBIST_SELECT, which selects `clk` into the core.
- `BUSY` output 1: high from INIT through COMPARE.
- `DONE` output 1: high in DONE state.
- `PASS` output 1: valid while DONE is high.
- `SIGNATURE` output 8: MISR contents.

## Operation

States: IDLE, INIT, LOAD, RUN, FLUSH, COMPARE, DONE.

- **Reset** (`RST_N` low, asynchronous): state goes to IDLE. Every output goes to 0. LFSR goes to `SEED`. MISR goes to 8'h00. Pattern count goes to 0.
- **IDLE**: on `START & RUNBIST_EN`, go to INIT. Otherwise stay.
- **INIT** (1 cycle):
  - `CL_RUNBIST`=1, `CL_RESET_SM`=1, `CL_X`=0.
  - LFSR loads `SEED`, MISR clears, count clears.
  - Go to LOAD.
- **LOAD** (1 cycle): `CL_ASSIGN_STATE`=1 and `CL_X`=`INIT_STATE`. Go to RUN.
- **RUN** (`PATTERNS` cycles):
  - `CL_X` = current LFSR value.
  - Each cycle: LFSR advances, MISR samples `CL_Y`, count increments.
  - After the cycle in which count reaches `PATTERNS`, go to FLUSH.
- **FLUSH** (1 cycle): `CL_X`=0. MISR samples `CL_Y`, which is the response to the last pattern. Go to COMPARE.
- **COMPARE** (1 cycle): register `PASS` = (MISR == `GOLDEN`). Go to DONE.
- **DONE**:
  - `DONE`=1, `BUSY`=0, `CL_RUNBIST`=0.
  - `PASS` and `SIGNATURE` hold.
  - `START & RUNBIST_EN` starts a new run (go to INIT and clear `DONE`/`PASS`).
  - `RUNBIST_EN` low: go to IDLE.

LFSR (x^4+x^3+1, period 15): next = {l[2:0], l[3]^l[2]}.

MISR:
- next = {m[6:0], fb} ^ {4'b0000, `CL_Y`}
- fb = m[7]^m[5]^m[4]^m[3]
- `SIGNATURE` = m at all times.

Boundary rules:
- `RUNBIST_EN` falling in any state from INIT to COMPARE aborts the run. Next cycle: IDLE, with all `CL_*` outputs, `BUSY`, `DONE` and `PASS` at 0. `SIGNATURE` holds its partial value.
- `START` while BUSY is ignored.
- `START` held high continuously in DONE restarts immediately. This behaviour is intended.
- The count is 8 bits, so `PATTERNS`=255 does not wrap before termination.
- The LFSR wraps freely every 15 patterns.

## Timing

- Start of run: `START` high at edge N (IDLE). INIT is during cycle N+1, LOAD during N+2, and RUN during N+3 .. N+2+`PATTERNS`.
- Then FLUSH at N+3+`PATTERNS` and COMPARE at N+4+`PATTERNS`.
- `DONE`/`PASS` are visible from cycle N+5+`PATTERNS`.
- MISR samples `PATTERNS`+1 values: `INIT_STATE` in the first RUN cycle, then the response to each pattern.
- All outputs are registered. There is no combinational path from `CL_Y` to any output other than through the MISR.

## Test plan

- **Reset mid-RUN**: assert `RST_N` low asynchronously during RUN. All outputs must be 0 immediately, without waiting for a clock edge. After release the block is in IDLE.
- **Pattern order**: default parameters with `CL_Y` tied 4'b0000 and `GOLDEN`=8'h00.
  - `CL_X` in the RUN cycles must be 1001, 0011, 0110, 1101, 1010, …
  - Result: `SIGNATURE`=8'h00 and `PASS`=1 at cycle N+20.
- **Signature arithmetic**: `PATTERNS`=1, `CL_Y` tied 4'b0001, `GOLDEN`=8'h03.
  - Required: `SIGNATURE`=8'h03 and `PASS`=1.
  - Repeat with `GOLDEN`=8'h04: required `PASS`=0.
- **Real core, default parameters**: connect the real core logic. Check `CL_RESET_SM` for exactly 1 cycle, then `CL_ASSIGN_STATE` for exactly 1 cycle with `CL_X`=0000. Check that `SIGNATURE` matches the bench reference model.
- **Abort**: drop `RUNBIST_EN` in the 5th RUN cycle.
  - Next cycle: IDLE, with `BUSY`, `DONE`, `PASS` and `CL_RUNBIST` all 0.
  - Then `START` with `RUNBIST_EN` high must perform a full, fresh run.
- **START handling**: pulse `START` during RUN and confirm it has no effect. Hold `START` high in DONE and confirm a back-to-back rerun with an identical `SIGNATURE`.

Source files
------------

// File: rtl/bist_sequencer.sv
// RUNBIST controller: reset, seed-load and LFSR pattern burst into the core
// logic, with MISR compaction of the responses and a golden-signature compare.
module bist_sequencer #(
    parameter logic [7:0] PATTERNS   = 8'd15,
    parameter logic [3:0] SEED       = 4'b1001,
    parameter logic [3:0] INIT_STATE = 4'b0000
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       RUNBIST_EN,
    input  logic       START,
    input  logic [7:0] GOLDEN,
    input  logic [3:0] CL_Y,
    output logic [3:0] CL_X,
    output logic       CL_RESET_SM,
    output logic       CL_ASSIGN_STATE,
    output logic       CL_RUNBIST,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] SIGNATURE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0] state_q, state_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [7:0] misr_q, misr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] x_q, x_d;
    logic       reset_sm_q, reset_sm_d;
    logic       assign_q, assign_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic       in_run;
    logic       go;
    logic       fb;
    logic [7:0] misr_step;
    logic [3:0] lfsr_step;

    assign go        = START & RUNBIST_EN;
    assign in_run    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign fb        = misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3];
    assign misr_step = {misr_q[6:0], fb} ^ {4'b0000, CL_Y};
    assign lfsr_step = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        // A dropped RUNBIST_EN abandons the run; the MISR keeps its partial value.
        if (in_run && !RUNBIST_EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go) state_d = S_INIT;
                S_INIT: begin
                    lfsr_d  = SEED;
                    misr_d  = 8'h00;
                    cnt_d   = 8'h00;
                    state_d = S_LOAD;
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    lfsr_d = lfsr_step;
                    misr_d = misr_step;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_d == PATTERNS) state_d = S_FLUSH;
                end
                S_FLUSH: begin
                    misr_d  = misr_step;
                    state_d = S_COMPARE;
                end
                S_COMPARE: state_d = S_DONE;
                S_DONE: begin
                    if (go) state_d = S_INIT;
                    else if (!RUNBIST_EN) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_comb begin
        reset_sm_d = (state_d == S_INIT);
        assign_d   = (state_d == S_LOAD);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        x_d        = 4'b0000;
        if (state_d == S_LOAD) x_d = INIT_STATE;
        if (state_d == S_RUN)  x_d = lfsr_d;
        pass_d = 1'b0;
        if (state_d == S_DONE) begin
            pass_d = (state_q == S_COMPARE) ? (misr_q == GOLDEN) : pass_q;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            misr_q     <= 8'h00;
            cnt_q      <= 8'h00;
            x_q        <= 4'b0000;
            reset_sm_q <= 1'b0;
            assign_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            reset_sm_q <= reset_sm_d;
            assign_q   <= assign_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign CL_X            = x_q;
    assign CL_RESET_SM     = reset_sm_q;
    assign CL_ASSIGN_STATE = assign_q;
    assign CL_RUNBIST      = busy_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign PASS            = pass_q;
    assign SIGNATURE       = misr_q;

endmodule
